// File: rtl/spi_fpga_pkg.sv
// Shared types and constants for the spi_fpga master family.
// Holds the state encoding, the SPI mode constants and the default word size.
package spi_fpga_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  localparam logic MODE0_CPOL = 1'b0;
  localparam logic MODE0_CPHA = 1'b0;

  localparam int DEFAULT_PACK_LENGTH = 8;

endpackage

// File: rtl/spi_fpga_half_period_timer.sv
// SCLK half-period divider: tc pulses on the HALF_PERIOD-th enabled clock.
// Zero latency from div_q to tc; clear takes priority over enable, no backpressure.
module spi_fpga_half_period_timer #(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int DW = $clog2(HALF_PERIOD) + 1;
  localparam logic [DW-1:0] LAST = DW'(HALF_PERIOD - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;

  assign tc = enable && (div_q == LAST);

  always_comb begin
    div_d = div_q;
    if (clear) begin
      div_d = '0;
    end else if (enable) begin
      div_d = div_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/spi_fpga_master_cpha_eq_0_cpol_eq_0.sv
// Mode-0 SPI master, MSB first: one full-duplex PACK_LENGTH-bit transfer per accepted start.
// Done pulses (2*PACK_LENGTH+1)*HALF_PERIOD clocks after accept; starts outside IDLE/GAP end are dropped.
module spi_fpga_master_cpha_eq_0_cpol_eq_0
  import spi_fpga_pkg::*;
#(
  parameter int PACK_LENGTH = DEFAULT_PACK_LENGTH,
  parameter int HALF_PERIOD = 2
) (
  input  logic                   IN_CLK,
  input  logic                   IN_RESET_N,
  input  logic                   IN_START,
  input  logic [PACK_LENGTH-1:0] IN_TRANSMIT_DATA,
  input  logic                   MISO,
  output logic                   MOSI,
  output logic                   SCLK,
  output logic                   CS,
  output logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA,
  output logic                   OUT_BUSY,
  output logic                   OUT_DONE
);

  localparam int BW = $clog2(PACK_LENGTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(PACK_LENGTH - 1);
  localparam logic SAMPLE_ON_LEAD = (MODE0_CPHA == 1'b0);

  spi_state_e state_q, state_d;

  logic [PACK_LENGTH-1:0] tx_q, tx_d;
  logic [PACK_LENGTH-1:0] rx_q, rx_d;
  logic [PACK_LENGTH-1:0] rdata_q, rdata_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic                   cs_q, cs_d;
  logic                   sclk_q, sclk_d;
  logic                   mosi_q, mosi_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic tc;
  logic accept;

  spi_fpga_half_period_timer #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_timer (
    .clk   (IN_CLK),
    .rst_n (IN_RESET_N),
    .clear (tc || (state_q == ST_IDLE)),
    .enable(state_q != ST_IDLE),
    .tc    (tc)
  );

  // The GAP terminal count doubles as an accept edge so a held start gives back-to-back words.
  assign accept = IN_START && ((state_q == ST_IDLE) || ((state_q == ST_GAP) && tc));

  always_ff @(posedge IN_CLK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (IN_START) state_d = ST_SETUP;
      ST_SETUP: if (tc) state_d = ST_HIGH;
      ST_HIGH:  if (tc) state_d = (bit_q == LAST_BIT) ? ST_HOLD : ST_LOW;
      ST_LOW:   if (tc) state_d = ST_HIGH;
      ST_HOLD:  if (tc) state_d = ST_GAP;
      ST_GAP:   if (tc) state_d = IN_START ? ST_SETUP : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    bit_d   = bit_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_SETUP, ST_LOW: begin
        if (tc) begin
          sclk_d = ~MODE0_CPOL;
          if (SAMPLE_ON_LEAD) rx_d = {rx_q[PACK_LENGTH-2:0], MISO};
        end
      end
      ST_HIGH: begin
        if (tc) begin
          sclk_d = MODE0_CPOL;
          if (bit_q != LAST_BIT) begin
            mosi_d = tx_q[PACK_LENGTH-2];
            tx_d   = {tx_q[PACK_LENGTH-2:0], 1'b0};
            bit_d  = bit_q + BW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (tc) begin
          cs_d    = 1'b1;
          rdata_d = rx_q;
          done_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (tc && !IN_START) begin
          mosi_d = 1'b0;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (accept) begin
      tx_d   = IN_TRANSMIT_DATA;
      cs_d   = 1'b0;
      mosi_d = IN_TRANSMIT_DATA[PACK_LENGTH-1];
      busy_d = 1'b1;
      bit_d  = '0;
    end
  end

  always_ff @(posedge IN_CLK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      bit_q   <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= MODE0_CPOL;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      bit_q   <= bit_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign MOSI             = mosi_q;
  assign SCLK             = sclk_q;
  assign CS               = cs_q;
  assign OUT_RECEIVE_DATA = rdata_q;
  assign OUT_BUSY         = busy_q;
  assign OUT_DONE         = done_q;

endmodule

// File: tb/tb_spi_fpga_master_cpha_eq_0_cpol_eq_0.sv
// Bench for the mode-0 master: default (8b, H=2) and 16b/H=1 instances against a behavioural slave
// and a per-cycle waveform model derived from the transfer timing rules.
module tb_spi_fpga_master_cpha_eq_0_cpol_eq_0;

  typedef struct {
    logic [15:0] ld;
    logic [15:0] rx;
    int          cnt;
    logic        miso;
    logic        pcs;
    logic        psclk;
    logic        pmosi;
    int          since;
  } slv_t;

  typedef struct {
    int          w;
    logic [15:0] tx;
    logic [15:0] sw;
    logic [15:0] exp_rx;
    logic [15:0] exp_srx;
    int          cs_low;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start0, start1;
  logic [7:0]  tx0, rx0;
  logic [15:0] tx1, rx1;
  logic        mosi0, sclk0, cs0, busy0, done0, miso0;
  logic        mosi1, sclk1, cs1, busy1, done1, miso1;
  logic [15:0] sword0, sword1;
  slv_t        sl0, sl1;
  int          nvec = 0;
  int          nerr = 0;

  assign miso0 = sl0.miso;
  assign miso1 = sl1.miso;

  spi_fpga_master_cpha_eq_0_cpol_eq_0 dut0 (
    .IN_CLK(clk), .IN_RESET_N(rst_n), .IN_START(start0), .IN_TRANSMIT_DATA(tx0),
    .MISO(miso0), .MOSI(mosi0), .SCLK(sclk0), .CS(cs0),
    .OUT_RECEIVE_DATA(rx0), .OUT_BUSY(busy0), .OUT_DONE(done0)
  );

  spi_fpga_master_cpha_eq_0_cpol_eq_0 #(.PACK_LENGTH(16), .HALF_PERIOD(1)) dut1 (
    .IN_CLK(clk), .IN_RESET_N(rst_n), .IN_START(start1), .IN_TRANSMIT_DATA(tx1),
    .MISO(miso1), .MOSI(mosi1), .SCLK(sclk1), .CS(cs1),
    .OUT_RECEIVE_DATA(rx1), .OUT_BUSY(busy1), .OUT_DONE(done1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mode-0 slave: presents MSB at CS fall, samples MOSI on SCLK rise, advances on SCLK fall.
  function automatic slv_t slave_step(slv_t s, logic cs, logic sclk, logic mosi,
                                      logic [15:0] word, int n);
    slv_t r = s;
    if (s.pcs === 1'b1 && cs === 1'b0) begin
      r.ld = word; r.cnt = 0; r.rx = '0; r.miso = word[n-1];
    end else if (cs === 1'b0 && s.psclk === 1'b0 && sclk === 1'b1) begin
      r.rx = {s.rx[14:0], mosi};
    end else if (cs === 1'b0 && s.psclk === 1'b1 && sclk === 1'b0) begin
      r.cnt = s.cnt + 1;
      if (r.cnt < n) r.miso = s.ld[n-1-r.cnt];
    end
    r.since = (mosi !== s.pmosi) ? 0 : s.since + 1;
    r.pcs = cs; r.psclk = sclk; r.pmosi = mosi;
    return r;
  endfunction

  task automatic mon(input string tag, input slv_t o, input slv_t nw,
                     input logic cs, input logic sclk, input int h);
    if (o.psclk === 1'b0 && sclk === 1'b1) chk({tag, " mosi_setup"}, 32'(nw.since >= h), 1);
    if (o.pcs === 1'b1 && cs === 1'b1) chk({tag, " sclk_idle"}, 32'(sclk), 0);
  endtask

  task automatic tick();
    slv_t n0, n1;
    @(negedge clk);
    n0 = slave_step(sl0, cs0, sclk0, mosi0, sword0, 8);
    n1 = slave_step(sl1, cs1, sclk1, mosi1, sword1, 16);
    mon("m0", sl0, n0, cs0, sclk0, 2);
    mon("m1", sl1, n1, cs1, sclk1, 1);
    sl0 = n0;
    sl1 = n1;
  endtask

  task automatic rd(input int w, output logic cs, output logic sclk, output logic mosi,
                    output logic busy, output logic done, output logic [15:0] rx, output logic [15:0] srx);
    if (w == 0) begin
      cs = cs0; sclk = sclk0; mosi = mosi0; busy = busy0; done = done0; rx = {8'h00, rx0}; srx = sl0.rx;
    end else begin
      cs = cs1; sclk = sclk1; mosi = mosi1; busy = busy1; done = done1; rx = rx1; srx = sl1.rx;
    end
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 0) start0 = v; else start1 = v;
  endtask

  // One transfer checked cycle by cycle; t counts clocks after the accepting edge.
  task automatic xfer(input int w, input logic [15:0] tx, input logic [15:0] sw, input bit hold,
                      input int pulse_at, input int rst_at,
                      output int cs_low, output int rises, output int dones);
    int n, h, L, G, last, k;
    logic cs, sclk, mosi, busy, done, psclk, e_sclk, e_mosi;
    logic [15:0] rx, srx, mask;
    n = (w == 0) ? 8 : 16;
    h = (w == 0) ? 2 : 1;
    L = (2 * n + 1) * h;
    G = (2 * n + 2) * h;
    mask = (w == 0) ? 16'h00FF : 16'hFFFF;
    cs_low = 0; rises = 0; dones = 0; psclk = 1'b0;
    if (w == 0) begin sword0 = sw; tx0 = tx[7:0]; end
    else begin sword1 = sw; tx1 = tx; end
    set_start(w, 1'b1);
    last = hold ? G - 1 : G;
    for (int t = 0; t <= last; t++) begin
      tick();
      rd(w, cs, sclk, mosi, busy, done, rx, srx);
      k = t / (2 * h);
      if (k > n - 1) k = n - 1;
      e_sclk = (t < L) && (((t / h) % 2) == 1);
      e_mosi = (t < G) ? tx[n-1-k] : 1'b0;
      chk($sformatf("cs%0d t=%0d", w, t), 32'(cs), (t < L) ? 0 : 1);
      chk($sformatf("sclk%0d t=%0d", w, t), 32'(sclk), 32'(e_sclk));
      chk($sformatf("mosi%0d t=%0d", w, t), 32'(mosi), 32'(e_mosi));
      chk($sformatf("busy%0d t=%0d", w, t), 32'(busy), (t < G) ? 1 : 0);
      chk($sformatf("done%0d t=%0d", w, t), 32'(done), (t == L) ? 1 : 0);
      if (t == L) begin
        chk($sformatf("rx%0d", w), 32'(rx), 32'(sw & mask));
        chk($sformatf("slave_rx%0d", w), 32'(srx & mask), 32'(tx & mask));
      end
      if (cs === 1'b0) cs_low++;
      if (psclk === 1'b0 && sclk === 1'b1) rises++;
      if (done === 1'b1) dones++;
      psclk = sclk;
      if (t == 0) begin
        if (!hold) set_start(w, 1'b0);
        if (w == 0) tx0 = ~tx0; else tx1 = ~tx1;
      end
      if (t + 1 == pulse_at) set_start(w, 1'b1);
      if (t == pulse_at) set_start(w, 1'b0);
      if (t + 1 == rst_at) begin
        rst_n = 1'b0;
        #1;
        rd(w, cs, sclk, mosi, busy, done, rx, srx);
        chk("rst cs", 32'(cs), 1);
        chk("rst sclk", 32'(sclk), 0);
        chk("rst mosi", 32'(mosi), 0);
        chk("rst rx", 32'(rx), 0);
        chk("rst busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
          tick();
          rd(w, cs, sclk, mosi, busy, done, rx, srx);
          chk("rst done", 32'(done), 0);
          chk("rst cs hold", 32'(cs), 1);
          if (done === 1'b1) dones++;
        end
        rst_n = 1'b1;
        return;
      end
    end
  endtask

  vec_t tbl[4];

  initial begin
    int cl, ri, dn;
    logic [15:0] a, b;
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    tx0 = '0; tx1 = '0; sword0 = '0; sword1 = '0;
    sl0 = '{ld: 16'h0, rx: 16'h0, cnt: 0, miso: 1'b0, pcs: 1'b1, psclk: 1'b0, pmosi: 1'b0, since: 0};
    sl1 = sl0;

    tbl[0] = '{w: 0, tx: 16'h00A5, sw: 16'h003C, exp_rx: 16'h003C, exp_srx: 16'h00A5, cs_low: 34};
    tbl[1] = '{w: 1, tx: 16'h8001, sw: 16'hFFFE, exp_rx: 16'hFFFE, exp_srx: 16'h8001, cs_low: 33};
    tbl[2] = '{w: 0, tx: 16'h0000, sw: 16'h00FF, exp_rx: 16'h00FF, exp_srx: 16'h0000, cs_low: 34};
    tbl[3] = '{w: 0, tx: 16'h00FF, sw: 16'h0081, exp_rx: 16'h0081, exp_srx: 16'h00FF, cs_low: 34};

    tick(); tick();
    chk("reset cs0", 32'(cs0), 1);     chk("reset cs1", 32'(cs1), 1);
    chk("reset sclk0", 32'(sclk0), 0); chk("reset sclk1", 32'(sclk1), 0);
    chk("reset mosi0", 32'(mosi0), 0); chk("reset mosi1", 32'(mosi1), 0);
    chk("reset rx0", 32'(rx0), 0);     chk("reset rx1", 32'(rx1), 0);
    chk("reset busy0", 32'(busy0), 0); chk("reset busy1", 32'(busy1), 0);
    chk("reset done0", 32'(done0), 0); chk("reset done1", 32'(done1), 0);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      xfer(tbl[i].w, tbl[i].tx, tbl[i].sw, 1'b0, -1, -1, cl, ri, dn);
      chk($sformatf("tbl%0d cs_low", i), 32'(cl), 32'(tbl[i].cs_low));
      chk($sformatf("tbl%0d rises", i), 32'(ri), (tbl[i].w == 0) ? 8 : 16);
      chk($sformatf("tbl%0d dones", i), 32'(dn), 1);
      chk($sformatf("tbl%0d rx", i), (tbl[i].w == 0) ? 32'(rx0) : 32'(rx1), 32'(tbl[i].exp_rx));
      chk($sformatf("tbl%0d slave", i), (tbl[i].w == 0) ? 32'(sl0.rx) : 32'(sl1.rx), 32'(tbl[i].exp_srx));
    end

    // Start held high: second word is accepted on the GAP terminal edge.
    xfer(0, 16'h00C3, 16'h0096, 1'b1, -1, -1, cl, ri, dn);
    chk("b2b first dones", 32'(dn), 1);
    xfer(0, 16'h0017, 16'h00E8, 1'b0, -1, -1, cl, ri, dn);
    chk("b2b second dones", 32'(dn), 1);
    chk("b2b second rx", 32'(rx0), 32'h00E8);

    // Start pulse mid-transfer must not queue a second word.
    xfer(0, 16'h0066, 16'h005A, 1'b0, 5, -1, cl, ri, dn);
    chk("pulse dones", 32'(dn), 1);
    tick();
    chk("pulse no requeue busy", 32'(busy0), 0);
    chk("pulse no requeue cs", 32'(cs0), 1);

    // Asynchronous abort, then a clean transfer.
    xfer(0, 16'h00F0, 16'h000F, 1'b0, -1, 11, cl, ri, dn);
    chk("abort dones", 32'(dn), 0);
    tick();
    xfer(0, 16'h0033, 16'h00CC, 1'b0, -1, -1, cl, ri, dn);
    chk("post-abort dones", 32'(dn), 1);
    chk("post-abort rx", 32'(rx0), 32'h00CC);

    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom_range(0, 255));
      b = 16'($urandom_range(0, 255));
      xfer(0, a, b, 1'b0, -1, -1, cl, ri, dn);
      chk("rand0 cs_low", 32'(cl), 34);
      chk("rand0 rises", 32'(ri), 8);
    end
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      xfer(1, a, b, 1'b0, -1, -1, cl, ri, dn);
      chk("rand1 cs_low", 32'(cl), 33);
      chk("rand1 rises", 32'(ri), 16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
